// File: rtl/simmem_pkg.sv
// Shared types and timing constants for the simulated memory.
package simmem_pkg;

  localparam int unsigned AxIdWidth = 4;
  localparam int unsigned AxAddrWidth = 16;
  localparam int unsigned AxLenWidth = 8;
  localparam int unsigned AxSizeWidth = 3;
  localparam int unsigned AxBurstWidth = 2;

  localparam int unsigned RowBufferLenWidth = 8;

  localparam int unsigned WriteRespBankAddrWidth = 4;
  localparam int unsigned ReadDataBankAddrWidth = 5;

  localparam int unsigned RowHitCost = 10;
  localparam int unsigned PrechargeCost = 50;
  localparam int unsigned ActivationCost = 45;

  typedef struct packed {
    logic [AxIdWidth-1:0]    id;
    logic [AxAddrWidth-1:0]  addr;
    logic [AxLenWidth-1:0]   burst_length;
    logic [AxSizeWidth-1:0]  burst_size;
    logic [AxBurstWidth-1:0] burst_type;
  } waddr_t;

  typedef struct packed {
    logic [AxIdWidth-1:0]    id;
    logic [AxAddrWidth-1:0]  addr;
    logic [AxLenWidth-1:0]   burst_length;
    logic [AxSizeWidth-1:0]  burst_size;
    logic [AxBurstWidth-1:0] burst_type;
  } raddr_t;

  typedef logic [WriteRespBankAddrWidth-1:0] write_iid_t;
  typedef logic [ReadDataBankAddrWidth-1:0]  read_iid_t;

  typedef logic [RowBufferLenWidth-1:0] row_id_t;

  typedef enum logic [1:0] {
    StIdle,
    StService,
    StRelease,
    StPrecharge
  } sched_state_e;

endpackage

// File: rtl/simmem_delay_scheduler_row_cost.sv
// Service cost of one access given the row buffer state and the burst length.
module simmem_row_cost #(
  parameter int unsigned RowHitCost     = simmem_pkg::RowHitCost,
  parameter int unsigned PrechargeCost  = simmem_pkg::PrechargeCost,
  parameter int unsigned ActivationCost = simmem_pkg::ActivationCost,
  parameter int unsigned CntWidth       = 9
) (
  input  logic                                  row_open_i,
  input  simmem_pkg::row_id_t                   open_row_i,
  input  simmem_pkg::row_id_t                   req_row_i,
  input  logic [simmem_pkg::AxLenWidth-1:0]     burst_length_i,
  output logic [CntWidth-1:0]                   cost_o
);
  import simmem_pkg::*;

  logic [CntWidth-1:0] base;

  always_comb begin
    if (!row_open_i) begin
      base = CntWidth'(ActivationCost + RowHitCost);
    end else if (open_row_i == req_row_i) begin
      base = CntWidth'(RowHitCost);
    end else begin
      base = CntWidth'(PrechargeCost + ActivationCost + RowHitCost);
    end
    cost_o = base + CntWidth'(burst_length_i);
  end

endmodule

// File: rtl/simmem_delay_scheduler.sv
// Shares one DRAM rank between write and read requests and releases each iid after its delay.
// Define SIMMEM_CLOSED_PAGE_EN for a closed-page policy with an explicit precharge phase.
module simmem_delay_scheduler #(
  parameter int unsigned RowHitCost     = simmem_pkg::RowHitCost,
  parameter int unsigned PrechargeCost  = simmem_pkg::PrechargeCost,
  parameter int unsigned ActivationCost = simmem_pkg::ActivationCost,
  parameter int unsigned CntWidth       =
      $clog2(PrechargeCost + ActivationCost + RowHitCost + 2**simmem_pkg::AxLenWidth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  simmem_pkg::waddr_t     waddr_i,
  input  simmem_pkg::write_iid_t waddr_iid_i,
  input  logic                   waddr_valid_i,
  output logic                   waddr_ready_o,
  input  simmem_pkg::raddr_t     raddr_i,
  input  simmem_pkg::read_iid_t  raddr_iid_i,
  input  logic                   raddr_valid_i,
  output logic                   raddr_ready_o,
  output logic                   release_valid_o,
  input  logic                   release_ready_i,
  output logic                   release_is_write_o,
  output simmem_pkg::write_iid_t release_write_iid_o,
  output simmem_pkg::read_iid_t  release_read_iid_o
);
  import simmem_pkg::*;

  if (CntWidth < $clog2(PrechargeCost + ActivationCost + RowHitCost + 2**AxLenWidth)) begin
    : gen_cnt_width_check
    $error("CntWidth cannot hold the largest access cost");
  end
  if (RowHitCost < 3) begin : gen_row_hit_check
    $error("RowHitCost must be at least 3");
  end

  sched_state_e        state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                row_open_q, row_open_d;
  row_id_t             open_row_q, open_row_d;
  logic                prio_w_q, prio_w_d;
  logic                is_write_q, is_write_d;
  write_iid_t          wiid_q, wiid_d;
  read_iid_t           riid_q, riid_d;

  logic                  w_grant, r_grant;
  row_id_t               req_row;
  logic [AxLenWidth-1:0] req_len;
  logic [CntWidth-1:0]   cost;

  // Only the row bits of the address matter to the timing model.
  logic unused_req_fields;
  assign unused_req_fields = ^{waddr_i.id, waddr_i.addr[RowBufferLenWidth-1:0],
                               waddr_i.burst_size, waddr_i.burst_type,
                               raddr_i.id, raddr_i.addr[RowBufferLenWidth-1:0],
                               raddr_i.burst_size, raddr_i.burst_type};

  assign req_row = w_grant ? waddr_i.addr[AxAddrWidth-1:RowBufferLenWidth]
                           : raddr_i.addr[AxAddrWidth-1:RowBufferLenWidth];
  assign req_len = w_grant ? waddr_i.burst_length : raddr_i.burst_length;

  simmem_row_cost #(
    .RowHitCost    (RowHitCost),
    .PrechargeCost (PrechargeCost),
    .ActivationCost(ActivationCost),
    .CntWidth      (CntWidth)
  ) u_row_cost (
    .row_open_i    (row_open_q),
    .open_row_i    (open_row_q),
    .req_row_i     (req_row),
    .burst_length_i(req_len),
    .cost_o        (cost)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    prio_w_d   = prio_w_q;
    is_write_d = is_write_q;
    wiid_d     = wiid_q;
    riid_d     = riid_q;
    w_grant    = 1'b0;
    r_grant    = 1'b0;
    unique case (state_q)
      StIdle: begin
        w_grant = waddr_valid_i & (prio_w_q | ~raddr_valid_i);
        r_grant = raddr_valid_i & (~prio_w_q | ~waddr_valid_i);
        if (w_grant || r_grant) begin
          state_d    = StService;
          cnt_d      = cost - CntWidth'(1);
          is_write_d = w_grant;
          wiid_d     = w_grant ? waddr_iid_i : '0;
          riid_d     = w_grant ? '0 : raddr_iid_i;
          prio_w_d   = ~w_grant;
`ifndef SIMMEM_CLOSED_PAGE_EN
          row_open_d = 1'b1;
          open_row_d = req_row;
`endif
        end
      end
      StService: begin
        if (cnt_q == '0) begin
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StRelease: begin
        if (release_ready_i) begin
`ifdef SIMMEM_CLOSED_PAGE_EN
          state_d = StPrecharge;
          cnt_d   = CntWidth'(PrechargeCost - 1);
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef SIMMEM_CLOSED_PAGE_EN
      StPrecharge: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      prio_w_q   <= 1'b1;
      is_write_q <= 1'b0;
      wiid_q     <= '0;
      riid_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      prio_w_q   <= prio_w_d;
      is_write_q <= is_write_d;
      wiid_q     <= wiid_d;
      riid_q     <= riid_d;
    end
  end

  // Readies are forced low while reset is held so all outputs read 0 during reset.
  assign waddr_ready_o       = w_grant & ~rst_i;
  assign raddr_ready_o       = r_grant & ~rst_i;
  assign release_valid_o     = (state_q == StRelease);
  assign release_is_write_o  = is_write_q;
  assign release_write_iid_o = wiid_q;
  assign release_read_iid_o  = riid_q;

endmodule

// File: doc/simmem_delay_scheduler.md
Name: simmem_delay_scheduler

Overview:
- Timing model for the simulated memory: accepts write-address and read-address requests and shares one DRAM rank between them with round-robin arbitration.
- Models a single open-row buffer and computes each request's service delay from row hit, closed or conflict state plus burst length.
- Pulses a release for each request's internal identifier when its delay elapses; the write-response and read-data banks consume the release to free responses.

Parameters:
- RowHitCost, simmem_pkg::RowHitCost (10), cycles for a column access to the open row; must be >= 3.
- PrechargeCost, simmem_pkg::PrechargeCost (50), cycles to close an open row.
- ActivationCost, simmem_pkg::ActivationCost (45), cycles to open a row.
- CntWidth, $clog2(PrechargeCost+ActivationCost+RowHitCost+2**AxLenWidth), delay counter width (9 with defaults).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- waddr_i  in  $bits(waddr_t)  write address request.
- waddr_iid_i  in  WriteRespBankAddrWidth  internal id of the write request.
- waddr_valid_i  in  1  write request valid.
- waddr_ready_o  out  1  write request accepted.
- raddr_i  in  $bits(raddr_t)  read address request.
- raddr_iid_i  in  ReadDataBankAddrWidth  internal id of the read request.
- raddr_valid_i  in  1  read request valid.
- raddr_ready_o  out  1  read request accepted.
- release_valid_o  out  1  a request's delay has elapsed.
- release_ready_i  in  1  bank accepts the release.
- release_is_write_o  out  1  1 = write release, 0 = read release.
- release_write_iid_o  out  WriteRespBankAddrWidth  released write iid (valid when release_is_write_o is 1).
- release_read_iid_o  out  ReadDataBankAddrWidth  released read iid (valid when release_is_write_o is 0).

Behaviour:
- Single clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values:
  - State is IDLE, counter is 0, row is closed (row_open = 0, open_row = 0), priority is write.
  - All outputs are 0.
- Row id is addr[AxAddrWidth-1:RowBufferLenWidth], 8 bits. Beats = burst_length + 1.
- FSM states: IDLE, SERVICE, RELEASE, plus PRECHARGE (optional feature only).
- IDLE:
  - waddr_ready_o = waddr_valid_i & (prio_w | ~raddr_valid_i).
  - raddr_ready_o = raddr_valid_i & (~prio_w | ~waddr_valid_i).
  - Readies are 0 in every other state. At most one handshake per cycle.
  - On handshake:
    - Latch the iid and direction.
    - Compute cost = base + burst_length:
      - Open row matches: base = RowHitCost.
      - Row closed: base = ActivationCost + RowHitCost.
      - Different row open: base = PrechargeCost + ActivationCost + RowHitCost.
    - Load counter with cost-1.
    - Set open_row to the request's row, row_open = 1.
    - prio_w = ~granted_is_write.
    - Go to SERVICE.
- SERVICE:
  - Decrement the counter each cycle.
  - When counter == 0, go to RELEASE.
  - release_valid_o therefore rises exactly cost edges after the accepting edge.
- RELEASE:
  - release_valid_o = 1; release fields are held stable.
  - On release_ready_i, go to IDLE. A new request can be accepted in the cycle after the release handshake, never the same cycle.
- Cost arithmetic is unsigned at CntWidth and cannot overflow with the defaults. Counter width is checked by an elaboration assertion.
- Backpressure: release_ready_i low stalls the FSM in RELEASE indefinitely; no requests are accepted meanwhile.
- Priority only changes on a grant. A lone valid requester is always granted regardless of priority.
- Reset mid-operation: the pending request is dropped without a release, row returns to closed, priority returns to write.
- Release iid outputs are registered. The unused iid output is driven 0.

Optional Feature:
- Macro: SIMMEM_CLOSED_PAGE_EN.
- Defined (closed-page policy):
  - Every access pays base = ActivationCost + RowHitCost.
  - After the release handshake, the FSM enters PRECHARGE for exactly PrechargeCost cycles with readies held 0, then returns to IDLE.
  - row_open stays 0.
- Undefined: open-page policy as above; PRECHARGE state absent.

Decomposition:
- simmem_pkg already supplies the cost constants, waddr_t, raddr_t, write_iid_t, read_iid_t and the bank address widths.
- Add to simmem_pkg: typedef logic [RowBufferLenWidth-1:0] row_id_t (8 bits, for the 16-bit address) and the FSM state enum sched_state_e.
- One natural sub-module, simmem_row_cost: combinational (row_open, open_row, req_row, burst_length) -> cost. It is reused by later multi-bank work.

Test Plan:
- After reset, write addr 0x0100, len 0, iid 3 -> waddr_ready_o pulses, release_valid_o after 55 cycles with is_write = 1, write_iid = 3.
- Then read addr 0x01F0, len 3, iid 5 -> row hit, release after 13 cycles, read_iid = 5. Then write 0x0200, len 0 -> conflict, release after 105 cycles.
- Write and read both valid from reset -> write granted first, read granted after the write's release; two consecutive write-only requests both granted without waiting.
- Hold release_ready_i low for 20 cycles -> release_valid_o and iid stable, both readies stay 0, release completes the cycle ready rises.
- Assert rst_i mid-SERVICE -> all outputs 0 asynchronously, no release emitted; next request to 0x0100 costs 55 (row closed).
- With SIMMEM_CLOSED_PAGE_EN: two reads to 0x0100, len 0, back-to-back with release_ready_i tied 1 -> each release 55 cycles after acceptance; second accepted 51 cycles after first release handshake.
